// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Segment bit order is {dp,g,f,e,d,c,b,a}, so bit 0 is segment a.
package seg7_pkg;

  localparam int SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Number of lit cycles per digit slot for a given dim setting.
  // Large dim values bottom out at a single lit cycle.
  function automatic int slotOnWidth(input int prescale, input int dimVal);
    int w;
    w = prescale >> dimVal;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment pattern decoder; non-decimal nibbles decode to blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  output logic [7:0] pattern_o
);

  // Look up the segment pattern and overlay the decimal point.
  always_comb begin
    pattern_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    pattern_o = SEG_0;
      4'd1:    pattern_o = SEG_1;
      4'd2:    pattern_o = SEG_2;
      4'd3:    pattern_o = SEG_3;
      4'd4:    pattern_o = SEG_4;
      4'd5:    pattern_o = SEG_5;
      4'd6:    pattern_o = SEG_6;
      4'd7:    pattern_o = SEG_7;
      4'd8:    pattern_o = SEG_8;
      4'd9:    pattern_o = SEG_9;
      default: pattern_o = SEG_BLANK;
    endcase
    pattern_o[SEG_DP_BIT] = dp_i;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS 7-segment driver with double-buffered updates,
// leading-zero blanking, run-time polarity and PWM dimming.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1024,
  parameter int DIM_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    seg_pol,
  input  logic                    com_pol,
  input  logic                    blank_lz,
  input  logic [DIM_BITS-1:0]     dim,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   com_out,
  output logic [NUM_DIGITS-1:0]   com_oe,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 4 * NUM_DIGITS;

  logic [PW-1:0]         prescCnt_q, prescCnt_d;
  logic [IW-1:0]         digitIdx_q, digitIdx_d;
  logic                  frameStart_q, frameStart_d;
  logic [BW-1:0]         pendBcd_q, pendBcd_d;
  logic [NUM_DIGITS-1:0] pendDp_q, pendDp_d;
  logic [BW-1:0]         dispBcd_q, dispBcd_d;
  logic [NUM_DIGITS-1:0] dispDp_q, dispDp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] comOe_q;
  logic [NUM_DIGITS-1:0] litCom_q, litCom_d;
  logic [7:0]            litSeg_q, litSeg_d;

  logic [NUM_DIGITS-1:0] lzMask;
  logic                  allZeroAbove;
  logic [3:0]            curBcd;
  logic                  curDp;
  logic                  curBlank;
  logic [7:0]            decPattern;
  logic [PW:0]           slotWidth;

  // Advance the slot prescaler and digit index; flag the frame wrap so
  // frame_start is high while the counters sit at the start of digit 0.
  always_comb begin
    prescCnt_d   = prescCnt_q;
    digitIdx_d   = digitIdx_q;
    frameStart_d = 1'b0;
    if (ena) begin
      prescCnt_d = prescCnt_q + PW'(1);
      if (prescCnt_q == PW'(PRESCALE - 1)) begin
        if (digitIdx_q == IW'(NUM_DIGITS - 1)) begin
          digitIdx_d   = '0;
          frameStart_d = 1'b1;
        end else begin
          digitIdx_d = digitIdx_q + IW'(1);
        end
      end
    end
  end

  // Double buffering: loads land in the pending buffer and are promoted at
  // the frame boundary; a load on the boundary itself bypasses straight in.
  always_comb begin
    pendBcd_d = pendBcd_q;
    pendDp_d  = pendDp_q;
    dispBcd_d = dispBcd_q;
    dispDp_d  = dispDp_q;
    pending_d = pending_q;
    if (frameStart_q) begin
      if (load) begin
        dispBcd_d = bcd_in;
        dispDp_d  = dp_in;
      end else if (pending_q) begin
        dispBcd_d = pendBcd_q;
        dispDp_d  = pendDp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pendBcd_d = bcd_in;
      pendDp_d  = dp_in;
      pending_d = 1'b1;
    end
  end

  // Build the leading-zero mask from the top digit down and pick out the
  // active digit; uses the next display value so a frame swap shows at once.
  always_comb begin
    allZeroAbove = 1'b1;
    lzMask       = '0;
    curBcd       = '0;
    curDp        = 1'b0;
    curBlank     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allZeroAbove = allZeroAbove & (dispBcd_d[4*i +: 4] == 4'd0);
      lzMask[i]    = blank_lz & allZeroAbove & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digitIdx_q == IW'(i)) begin
        curBcd   = dispBcd_d[4*i +: 4];
        curDp    = dispDp_d[i];
        curBlank = lzMask[i];
      end
    end
  end

  seg7_decode u_decode (
    .bcd_i     (curBcd),
    .dp_i      (curDp),
    .pattern_o (decPattern)
  );

  // Light one common for the dimmed part of the slot; segments are driven
  // only while that common is lit to avoid ghosting into neighbours.
  always_comb begin
    litCom_d  = '0;
    litSeg_d  = '0;
    slotWidth = (PW+1)'(slotOnWidth(PRESCALE, int'(dim)));
    if (ena && ({1'b0, prescCnt_q} < slotWidth)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digitIdx_q == IW'(i)) begin
          litCom_d[i] = 1'b1;
        end
      end
      litSeg_d = curBlank ? {decPattern[SEG_DP_BIT], 7'b0} : decPattern;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescCnt_q   <= '0;
      digitIdx_q   <= '0;
      frameStart_q <= 1'b0;
      pendBcd_q    <= '0;
      pendDp_q     <= '0;
      dispBcd_q    <= '0;
      dispDp_q     <= '0;
      pending_q    <= 1'b0;
      comOe_q      <= '0;
      litCom_q     <= '0;
      litSeg_q     <= '0;
    end else begin
      prescCnt_q   <= prescCnt_d;
      digitIdx_q   <= digitIdx_d;
      frameStart_q <= frameStart_d;
      pendBcd_q    <= pendBcd_d;
      pendDp_q     <= pendDp_d;
      dispBcd_q    <= dispBcd_d;
      dispDp_q     <= dispDp_d;
      pending_q    <= pending_d;
      comOe_q      <= '1;
      litCom_q     <= litCom_d;
      litSeg_q     <= litSeg_d;
    end
  end

  assign seg_out     = litSeg_q ^ {8{~seg_pol}};
  assign com_out     = litCom_q ^ {NUM_DIGITS{~com_pol}};
  assign com_oe      = comOe_q;
  assign pending     = pending_q;
  assign frame_start = frameStart_q;

endmodule
